// File: rtl/mips_gpio_port.sv
// Memory-mapped bidirectional GPIO port: per-bit direction, input synchroniser, rising-edge IRQ flags with enable mask.
// Latency: writes land on the next sys_clk edge; reads are combinational; pin to DATA in SYNC_STAGES edges (+DEBOUNCE_CYCLES with debounce).
// Backpressure: none, every bus access completes in its own cycle. Optional debounce filter: define MIPS_GPIO_DEBOUNCE_EN.
module mips_gpio_port #(
    parameter int WIDTH           = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic             sys_clk,
    input  logic             rst_sync,
    input  logic             ce,
    input  logic             wr,
    input  logic [3:0]       addr,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    inout  wire  [WIDTH-1:0] port_io,
    output logic             irq
);

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_DIR  = 2'd1;
    localparam logic [1:0] REG_IEN  = 2'd2;
    localparam logic [1:0] REG_FLAG = 2'd3;

    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] irq_flag;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_last;
    logic [WIDTH-1:0] filtered;

    logic             wr_en;
    logic [WIDTH-1:0] flag_set;
    logic [WIDTH-1:0] flag_clr;
    logic [WIDTH-1:0] flag_nxt;
    logic [WIDTH-1:0] en_nxt;

    // byte-lane bits of the address carry no register selection
    logic             addr_unused;
    assign addr_unused = ^addr[1:0];

    assign wr_en     = ce & wr;
    assign sync_last = sync_q[SYNC_STAGES-1];

    // Pin drivers: a bit is driven only while configured as output; reset clears dir so pins float at once
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign port_io[i] = dir[i] ? out_reg[i] : 1'bz;
    end

    // Multi-flop synchroniser on the raw pin values
    always_ff @(posedge sys_clk or posedge rst_sync) begin
        if (rst_sync) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= port_io;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

`ifdef MIPS_GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0]    deb_cnt [WIDTH];
    logic [WIDTH-1:0] filt_q;

    // Per-bit debounce: the filtered value follows the synchroniser only after a run of differing cycles
    always_ff @(posedge sys_clk or posedge rst_sync) begin
        if (rst_sync) begin
            filt_q <= '0;
            for (int i = 0; i < WIDTH; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_last[i] == filt_q[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    filt_q[i]  <= sync_last[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign filtered = filt_q;
`else
    logic [31:0] debounce_unused;
    assign debounce_unused = DEBOUNCE_CYCLES;
    assign filtered        = sync_last;
`endif

    // Next-state for flags and enables; a new rising edge beats a same-cycle write-1-to-clear
    always_comb begin
        flag_set = filtered & ~prev & ~dir;
        flag_clr = '0;
        en_nxt   = irq_en;
        if (wr_en && addr[3:2] == REG_FLAG) flag_clr = data_i;
        if (wr_en && addr[3:2] == REG_IEN)  en_nxt   = data_i;
        flag_nxt = (irq_flag & ~flag_clr) | flag_set;
    end

    // Register file, edge-detect history and registered interrupt
    always_ff @(posedge sys_clk or posedge rst_sync) begin
        if (rst_sync) begin
            out_reg  <= '0;
            dir      <= '0;
            irq_en   <= '0;
            irq_flag <= '0;
            prev     <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_en && addr[3:2] == REG_DATA) out_reg <= data_i;
            if (wr_en && addr[3:2] == REG_DIR)  dir     <= data_i;
            irq_en   <= en_nxt;
            irq_flag <= flag_nxt;
            prev     <= filtered;
            irq      <= |(flag_nxt & en_nxt);
        end
    end

    // Single-cycle combinational read; outputs read back the driven value, inputs the filtered pin
    always_comb begin
        data_o = '0;
        if (ce && !wr) begin
            case (addr[3:2])
                REG_DATA: data_o = (dir & out_reg) | (~dir & filtered);
                REG_DIR:  data_o = dir;
                REG_IEN:  data_o = irq_en;
                default:  data_o = irq_flag;
            endcase
        end
    end

endmodule
